// File: rtl/b06_pkg.sv
// rtl/b06_pkg.sv - shared encodings and constants for the b06 counter/compare block
package b06_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'b00,
    C_RUN  = 2'b01,
    C_TERM = 2'b10,
    C_ACK  = 2'b11
  } cnt_state_e;

  localparam logic [1:0] CC_OFF    = 2'b00;
  localparam logic [1:0] CC_MATCH  = 2'b01;
  localparam logic [1:0] CC_COUNT  = 2'b10;
  localparam logic [1:0] CC_SAMPLE = 2'b11;

  localparam logic [7:0] LIMIT_RST = 8'hFF;

endpackage

// File: rtl/b06_cnt_cmp_if.sv
// rtl/b06_cnt_cmp_if.sv - handler-side signal bundle for b06_cnt_cmp
interface b06_cnt_cmp_if;
  logic [7:0] data_in;
  logic [7:0] match_in;
  logic [7:0] lim_in;
  logic       lim_load;
  logic [2:1] cc_mux;
  logic [2:1] uscite;
  logic       enable_count;
  logic       ackout;
  logic       eql;
  logic       cont_eql;
  logic [7:0] count;
  logic       busy;

  modport master (
    output data_in, match_in, lim_in, lim_load, cc_mux, uscite, enable_count, ackout,
    input  eql, cont_eql, count, busy
  );

  modport slave (
    input  data_in, match_in, lim_in, lim_load, cc_mux, uscite, enable_count, ackout,
    output eql, cont_eql, count, busy
  );
endinterface

// File: rtl/b06_cmp_sel.sv
// rtl/b06_cmp_sel.sv - compare-source mux and 8-bit equality, purely combinational
module b06_cmp_sel
  import b06_pkg::*;
(
  input  logic [2:1] cc_mux,
  input  logic [7:0] data_in,
  input  logic [7:0] match_in,
  input  logic [7:0] count,
  input  logic [7:0] sample,
  output logic       eq
);

  always_comb begin
    eq = 1'b0;
    case (cc_mux)
      CC_OFF:    eq = 1'b0;
      CC_MATCH:  eq = (data_in == match_in);
      CC_COUNT:  eq = (data_in == count);
      CC_SAMPLE: eq = (data_in == sample);
      default:   eq = 1'b0;
    endcase
  end

endmodule

// File: rtl/b06_cnt_cmp.sv
// rtl/b06_cnt_cmp.sv - terminal-count FSM, counter, limit/sample registers and registered compare
module b06_cnt_cmp
  import b06_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  b06_cnt_cmp_if.slave  bus
);

  cnt_state_e state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] limit_q, limit_d;
  logic [7:0] sample_q, sample_d;
  logic       eql_q, eql_d;
  logic       cont_eql_q, cont_eql_d;
  logic       at_term;
  logic       cmp_eq;
  logic       unused_uscite;

  assign unused_uscite = bus.uscite[1];

  // A zero limit terminates immediately rather than after a full 256-count wrap.
  assign at_term = (limit_q == 8'd0) || (count_q == limit_q - 8'd1);

  b06_cmp_sel u_cmp_sel (
    .cc_mux   (bus.cc_mux),
    .data_in  (bus.data_in),
    .match_in (bus.match_in),
    .count    (count_q),
    .sample   (sample_q),
    .eq       (cmp_eq)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= C_IDLE;
      count_q    <= 8'd0;
      limit_q    <= LIMIT_RST;
      sample_q   <= 8'd0;
      eql_q      <= 1'b0;
      cont_eql_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      sample_q   <= sample_d;
      eql_q      <= eql_d;
      cont_eql_q <= cont_eql_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (bus.enable_count) state_d = C_RUN;
      C_RUN:   if (bus.enable_count && at_term) state_d = C_TERM;
      C_TERM:  if (!bus.ackout) state_d = C_ACK;
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    cont_eql_d = cont_eql_q;
    limit_d    = limit_q;
    case (state_q)
      C_IDLE: begin
        count_d    = 8'd0;
        cont_eql_d = 1'b0;
        if (bus.lim_load) limit_d = bus.lim_in;
      end
      C_RUN: begin
        if (bus.enable_count) begin
          if (limit_q != 8'd0) count_d = count_q + 8'd1;
          cont_eql_d = at_term;
        end
      end
      C_TERM: cont_eql_d = 1'b1;
      C_ACK: begin
        count_d    = 8'd0;
        cont_eql_d = 1'b0;
      end
      default: begin
        count_d    = 8'd0;
        cont_eql_d = 1'b0;
      end
    endcase
    // Compare sees sample_q, so a same-edge capture is not bypassed.
    sample_d = bus.uscite[2] ? bus.data_in : sample_q;
    eql_d    = cmp_eq;
  end

  assign bus.eql      = eql_q;
  assign bus.cont_eql = cont_eql_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != C_IDLE);

endmodule

// File: tb/tb_b06_cnt_cmp.sv
// tb/tb_b06_cnt_cmp.sv - self-checking bench for b06_cnt_cmp
module tb_b06_cnt_cmp;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  b06_cnt_cmp_if bus ();

  b06_cnt_cmp dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:1] cc;
    logic [7:0] din;
    logic [7:0] mtch;
    logic       exp_eql;
  } cmp_vec_t;

  cmp_vec_t vecs[8];

  // Reference model: phase 0 idle, 1 counting, 2 at terminal, 3 acknowledging.
  int m_phase, m_count, m_limit, m_sample, m_eql;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_in      = 8'd0;
    bus.match_in     = 8'd0;
    bus.lim_in       = 8'd0;
    bus.lim_load     = 1'b0;
    bus.cc_mux       = 2'b00;
    bus.uscite       = 2'b00;
    bus.enable_count = 1'b0;
    bus.ackout       = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_count  = 0;
    m_limit  = 255;
    m_sample = 0;
    m_eql    = 0;
  endtask

  task automatic model_step(input logic rst_n);
    int n_eql;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (bus.cc_mux)
        2'b01:   n_eql = (int'(bus.data_in) == int'(bus.match_in));
        2'b10:   n_eql = (int'(bus.data_in) == m_count);
        2'b11:   n_eql = (int'(bus.data_in) == m_sample);
        default: n_eql = 0;
      endcase
      m_eql = n_eql;
      if (bus.uscite[2]) m_sample = int'(bus.data_in);
      case (m_phase)
        0: begin
          if (bus.lim_load) m_limit = int'(bus.lim_in);
          if (bus.enable_count) m_phase = 1;
        end
        1: if (bus.enable_count) begin
          if (m_limit == 0) m_phase = 2;
          else begin
            m_count = (m_count + 1) % 256;
            if (m_count == m_limit) m_phase = 2;
          end
        end
        2: if (!bus.ackout) m_phase = 3;
        default: begin
          m_count = 0;
          m_phase = 0;
        end
      endcase
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.data_in = 8'($urandom); bus.match_in = 8'($urandom); bus.lim_in = 8'($urandom);
      bus.lim_load = 1'($urandom); bus.cc_mux = 2'($urandom); bus.uscite = 2'($urandom);
      bus.enable_count = 1'($urandom); bus.ackout = 1'($urandom);
      tick();
    end
    reset = 1'b1;
    idle_inputs();
    check("rst_count", bus.count, 0);
    check("rst_eql", bus.eql, 0);
    check("rst_cont_eql", bus.cont_eql, 0);
    check("rst_busy", bus.busy, 0);

    // Terminal count at limit 3
    bus.lim_in = 8'd3; bus.lim_load = 1'b1;
    tick();
    bus.lim_load = 1'b0; bus.enable_count = 1'b1;
    tick();
    check("tc_run_count0", bus.count, 0);
    check("tc_run_busy", bus.busy, 1);
    tick(); check("tc_count1", bus.count, 1);
    tick(); check("tc_count2", bus.count, 2);
    check("tc_cont_before", bus.cont_eql, 0);
    tick(); check("tc_count3", bus.count, 3);
    check("tc_cont_at", bus.cont_eql, 1);
    tick(); check("tc_term_hold", bus.count, 3);
    check("tc_term_cont", bus.cont_eql, 1);
    bus.ackout = 1'b0;
    tick(); check("tc_ack_busy", bus.busy, 1);
    bus.ackout = 1'b1; bus.enable_count = 1'b0;
    tick();
    check("tc_idle_count", bus.count, 0);
    check("tc_idle_cont", bus.cont_eql, 0);
    check("tc_idle_busy", bus.busy, 0);

    // Pause and ignored late load, limit 5
    bus.lim_in = 8'd5; bus.lim_load = 1'b1;
    tick();
    bus.lim_load = 1'b0; bus.enable_count = 1'b1;
    tick();
    tick(); check("pz_count1", bus.count, 1);
    bus.enable_count = 1'b0;
    tick(); check("pz_hold", bus.count, 1);
    check("pz_busy", bus.busy, 1);
    bus.enable_count = 1'b1; bus.lim_in = 8'd2; bus.lim_load = 1'b1;
    tick(); check("pz_count2", bus.count, 2);
    bus.lim_load = 1'b0;
    tick(); check("pz_no_term_at_2", bus.cont_eql, 0);
    tick(); check("pz_count4", bus.count, 4);
    tick(); check("pz_count5", bus.count, 5);
    check("pz_cont5", bus.cont_eql, 1);
    bus.ackout = 1'b0;
    tick();
    bus.ackout = 1'b1; bus.enable_count = 1'b0;
    tick(); check("pz_idle", bus.busy, 0);

    // Compare mux table, counter idle at 0, sample cleared by reset
    do_reset();
    vecs[0] = '{2'b01, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{2'b00, 8'hA5, 8'hA5, 1'b0};
    vecs[2] = '{2'b10, 8'h00, 8'h11, 1'b1};
    vecs[3] = '{2'b10, 8'h01, 8'h01, 1'b0};
    vecs[4] = '{2'b01, 8'hA5, 8'h5A, 1'b0};
    vecs[5] = '{2'b11, 8'h00, 8'hFF, 1'b1};
    vecs[6] = '{2'b11, 8'h3C, 8'h3C, 1'b0};
    vecs[7] = '{2'b00, 8'h00, 8'h00, 1'b0};
    foreach (vecs[i]) begin
      bus.cc_mux = vecs[i].cc; bus.data_in = vecs[i].din; bus.match_in = vecs[i].mtch;
      tick();
      check($sformatf("cmp_vec%0d", i), bus.eql, vecs[i].exp_eql);
    end

    // Capture, then same-edge capture uses old sample
    idle_inputs();
    bus.uscite = 2'b11; bus.data_in = 8'h3C;
    tick();
    bus.uscite = 2'b00; bus.cc_mux = 2'b11;
    tick(); check("cap_eq", bus.eql, 1);
    bus.uscite = 2'b11; bus.data_in = 8'h55;
    tick(); check("cap_no_bypass", bus.eql, 0);
    bus.uscite = 2'b00;
    tick(); check("cap_new_sample", bus.eql, 1);

    // Zero limit, then reset while at terminal count
    idle_inputs();
    bus.lim_in = 8'd0; bus.lim_load = 1'b1;
    tick();
    bus.lim_load = 1'b0; bus.enable_count = 1'b1;
    tick();
    tick();
    check("z_term_count", bus.count, 0);
    check("z_term_cont", bus.cont_eql, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("z_rst_busy", bus.busy, 0);
    check("z_rst_cont", bus.cont_eql, 0);
    bus.enable_count = 1'b1;
    tick();
    tick(); check("ff_count1", bus.count, 1);
    check("ff_cont1", bus.cont_eql, 0);
    for (int i = 0; i < 253; i++) tick();
    check("ff_count254", bus.count, 254);
    check("ff_cont254", bus.cont_eql, 0);
    tick();
    check("ff_count255", bus.count, 255);
    check("ff_cont255", bus.cont_eql, 1);

    // Randomized run against the reference model
    idle_inputs();
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rn;
      int pick;
      rn = ($urandom_range(0, 59) != 0);
      reset = rn;
      bus.match_in = 8'($urandom_range(0, 3));
      pick = $urandom_range(0, 3);
      case (pick)
        0: bus.data_in = 8'(m_count);
        1: bus.data_in = bus.match_in;
        2: bus.data_in = 8'(m_sample);
        default: bus.data_in = 8'($urandom_range(0, 7));
      endcase
      bus.lim_in = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      bus.lim_load = 1'($urandom);
      bus.cc_mux = 2'($urandom);
      bus.uscite = 2'($urandom);
      bus.enable_count = ($urandom_range(0, 4) != 0);
      bus.ackout = ($urandom_range(0, 3) != 0);
      model_step(rn);
      tick();
      check($sformatf("rnd%0d_count", i), bus.count, m_count);
      check($sformatf("rnd%0d_eql", i), bus.eql, m_eql);
      check($sformatf("rnd%0d_cont", i), bus.cont_eql, (m_phase == 2 || m_phase == 3));
      check($sformatf("rnd%0d_busy", i), bus.busy, (m_phase != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/b06_cnt_cmp.md
B06_CNT_CMP -- requirements
Module: b06_cnt_cmp

Interface
REQ-001 The block SHALL use these ports (name  direction  width  meaning):
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-low; reset=0 at a rising clock edge resets the block.
REQ-004 data_in  in  8  value sampled and compared each cycle.
REQ-005 match_in  in  8  fixed match operand for cc_mux=01.
REQ-006 lim_in  in  8  terminal-count limit; loaded when lim_load=1.
REQ-007 lim_load  in  1  limit load strobe.
REQ-008 cc_mux  in  2 ([2:1])  compare-source select from the interrupt-handler FSM.
REQ-009 uscite  in  2 ([2:1])  handler status; uscite[2]=1 is the capture strobe.
REQ-010 enable_count  in  1  count enable from the handler FSM.
REQ-011 ackout  in  1  handler acknowledge; 0 while the handler sees terminal count.
REQ-012 eql  out  1  registered compare result, fed back to the handler.
REQ-013 cont_eql  out  1  registered terminal-count flag, fed back to the handler.
REQ-014 count  out  8  current counter value.
REQ-015 busy  out  1  1 when the counter FSM is not in C_IDLE.

Function
REQ-016 The counter FSM SHALL have exactly four states: C_IDLE, C_RUN, C_TERM, C_ACK.
REQ-017 C_IDLE: count=0 and cont_eql=0; lim_load=1 loads lim_in into the limit register; enable_count=1 moves the FSM to C_RUN without incrementing.
REQ-018 lim_load in any state other than C_IDLE SHALL be ignored.
REQ-019 C_RUN with enable_count=1: count increments by 1, wrapping 8-bit modulo 256.
REQ-020 C_RUN with enable_count=0: count holds and the FSM stays in C_RUN (pause).
REQ-021 C_RUN, enabled, count==limit-1: count becomes limit and the FSM moves to C_TERM; cont_eql=1 from the same edge.
REQ-022 limit==0: the first enabled C_RUN cycle moves to C_TERM with count held at 0.
REQ-023 C_TERM: count and cont_eql=1 hold, and enable_count is ignored; ackout=0 moves the FSM to C_ACK.
REQ-024 C_ACK: count clears to 0, cont_eql clears to 0, and the FSM moves unconditionally to C_IDLE; the limit is retained.
REQ-025 eql SHALL be registered with 1-cycle latency from its inputs, per cc_mux:
  - 00: eql=0.
  - 01: data_in==match_in.
  - 10: data_in==count (pre-edge value).
  - 11: data_in==sample.
REQ-026 The sample register SHALL load data_in on each edge with uscite[2]=1 and hold otherwise.
REQ-027 When a capture and a cc_mux=11 compare occur on the same edge, the compare SHALL use the old sample (no bypass).
REQ-028 eql is computed in every FSM state, independent of the counter FSM.
REQ-029 busy SHALL be a combinational decode of FSM state != C_IDLE.

Reset
REQ-030 reset=0 SHALL force, on the next edge: FSM=C_IDLE, count=0, limit=8'hFF, sample=0, eql=0, cont_eql=0.
REQ-031 Reset SHALL override all other inputs in every state, including mid-count and in C_TERM.
REQ-032 The block SHALL recover correctly from any illegal FSM encoding by going to C_IDLE on the next edge.

Structure
REQ-033 Package b06_pkg SHALL hold the counter-state encodings (C_IDLE=2'b00, C_RUN=01, C_TERM=10, C_ACK=11), the cc_mux codes, and the limit reset value.
REQ-034 The compare-source mux and equality logic SHALL be a single sub-module, b06_cmp_sel.
REQ-035 The counter FSM, counter, limit and sample registers SHALL live in b06_cnt_cmp.

Verification
REQ-036 Reset scenario: reset=0 for 2 cycles with random inputs -> count=0, eql=0, cont_eql=0, busy=0.
REQ-037 Terminal-count scenario: lim_in=3 with lim_load in C_IDLE, then enable_count=1 held -> count 1,2,3; cont_eql=1 on the edge count reaches 3; ackout=0 -> C_ACK, then count=0, cont_eql=0, busy=0.
REQ-038 Pause and late-load scenario: limit=5, enable_count toggled 1,0,1 -> count holds during the 0 cycle; lim_load in C_RUN is ignored and terminal count still occurs at 5.
REQ-039 Compare-mux scenario:
  - cc_mux=01, data_in=match_in=8'hA5 -> eql=1 next cycle.
  - cc_mux=00 with the same data -> eql=0.
  - cc_mux=10, data_in=count -> eql=1.
REQ-040 Capture scenario: uscite=11 with data_in=8'h3C, then cc_mux=11 with data_in=8'h3C -> eql=1; same-edge capture of 8'h55 with compare against 8'h55 -> eql=0.
REQ-041 Limit-edge and mid-count reset scenario: limit=0 -> C_TERM on the first enabled cycle with count=0; reset=0 asserted while in C_TERM -> C_IDLE and limit=8'hFF.
